// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared helpers for the bimodal branch target buffer.
package branch_predictor_pkg;

    localparam int GEN_W = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    function automatic logic [GEN_W-1:0] low_mask(input int w);
        return (w >= GEN_W) ? '1 : (GEN_W'(1) << w) - GEN_W'(1);
    endfunction

    function automatic logic [GEN_W-1:0] cnt_weak_taken(input int w);
        return GEN_W'(1) << (w - 1);
    endfunction

    function automatic logic [GEN_W-1:0] addr_index(input logic [GEN_W-1:0] a, input int idx_w);
        return (a >> 2) & low_mask(idx_w);
    endfunction

    function automatic logic [GEN_W-1:0] addr_tag(input logic [GEN_W-1:0] a, input int idx_w);
        return a >> (idx_w + 2);
    endfunction

    function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v, input int w);
        return (v == low_mask(w)) ? v : v + GEN_W'(1);
    endfunction

    function automatic logic [GEN_W-1:0] sat_dec(input logic [GEN_W-1:0] v);
        return (v == '0) ? v : v - GEN_W'(1);
    endfunction

endpackage

// File: rtl/branch_predictor_table.sv
// branch_predictor_table: direct-mapped entry storage, two async read ports, one write port.
module branch_predictor_table #(
    parameter int ENTRY_N = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 26,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic [IDX_W-1:0]  i_rd0_idx,
    output logic              o_rd0_valid,
    output logic [TAG_W-1:0]  o_rd0_tag,
    output logic [ADDR_W-1:0] o_rd0_target,
    output logic [CNT_W-1:0]  o_rd0_cnt,
    input  logic [IDX_W-1:0]  i_rd1_idx,
    output logic              o_rd1_valid,
    output logic [TAG_W-1:0]  o_rd1_tag,
    output logic [ADDR_W-1:0] o_rd1_target,
    output logic [CNT_W-1:0]  o_rd1_cnt,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [ADDR_W-1:0] i_wr_target,
    input  logic [CNT_W-1:0]  i_wr_cnt
);

    logic [ENTRY_N-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRY_N];
    logic [ADDR_W-1:0]  r_target [ENTRY_N];
    logic [CNT_W-1:0]   r_cnt    [ENTRY_N];

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) r_valid <= '0;
        else if (i_we) r_valid[i_wr_idx] <= 1'b1;
    end

    // payload needs no reset: it is only trusted behind its valid bit
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]    <= i_wr_tag;
            r_target[i_wr_idx] <= i_wr_target;
            r_cnt[i_wr_idx]    <= i_wr_cnt;
        end
    end

    assign o_rd0_valid  = r_valid[i_rd0_idx];
    assign o_rd0_tag    = r_tag[i_rd0_idx];
    assign o_rd0_target = r_target[i_rd0_idx];
    assign o_rd0_cnt    = r_cnt[i_rd0_idx];
    assign o_rd1_valid  = r_valid[i_rd1_idx];
    assign o_rd1_tag    = r_tag[i_rd1_idx];
    assign o_rd1_target = r_target[i_rd1_idx];
    assign o_rd1_cnt    = r_cnt[i_rd1_idx];

endmodule

// File: rtl/branch_predictor_bimodal.sv
// branch_predictor_bimodal: BTB with saturating direction counters and mispredict statistic.
module branch_predictor_bimodal
    import branch_predictor_pkg::*;
#(
    parameter int ENTRY_N = 16,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
)(
    input  logic              iCLOCK,
    input  logic              iRESET_SYNC,
    input  logic              iFLUSH,
    input  logic              iSEARCH_STB,
    input  logic [ADDR_W-1:0] iSEARCH_INST_ADDR,
    input  logic              iSEARCH_LOCK,
    output logic              oSEARCH_VALID,
    output logic              oSEARCH_PREDICT_BRANCH,
    output logic [ADDR_W-1:0] oSEARCH_ADDR,
    input  logic              iJUMP_STB,
    input  logic              iJUMP_HIT,
    input  logic [ADDR_W-1:0] iJUMP_ADDR,
    input  logic [ADDR_W-1:0] iJUMP_INST_ADDR,
    output logic [STAT_W-1:0] oSTAT_MISPREDICT
);

    localparam int IDX_W = clog2(ENTRY_N);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_WEAK_TAKEN = CNT_W'(cnt_weak_taken(CNT_W));

    logic [IDX_W-1:0]  w_s_idx, w_j_idx;
    logic [TAG_W-1:0]  w_s_tag, w_j_tag, w_s_rtag, w_j_rtag;
    logic              w_s_rvalid, w_j_rvalid;
    logic [ADDR_W-1:0] w_s_target, w_j_target;
    logic [CNT_W-1:0]  w_s_cnt, w_j_cnt;
    logic              w_s_pred, w_j_hit, w_j_pred, w_mis, w_we;
    logic [CNT_W-1:0]  w_wr_cnt;
    logic [ADDR_W-1:0] w_wr_target;
    logic              r_valid, r_pred;
    logic [ADDR_W-1:0] r_addr;
    logic [STAT_W-1:0] r_stat;

    assign w_s_idx = IDX_W'(addr_index(GEN_W'(iSEARCH_INST_ADDR), IDX_W));
    assign w_s_tag = TAG_W'(addr_tag(GEN_W'(iSEARCH_INST_ADDR), IDX_W));
    assign w_j_idx = IDX_W'(addr_index(GEN_W'(iJUMP_INST_ADDR), IDX_W));
    assign w_j_tag = TAG_W'(addr_tag(GEN_W'(iJUMP_INST_ADDR), IDX_W));

    branch_predictor_table #(
        .ENTRY_N(ENTRY_N), .IDX_W(IDX_W), .TAG_W(TAG_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) u_table (
        .i_clk(iCLOCK), .i_rst(iRESET_SYNC), .i_flush(iFLUSH),
        .i_rd0_idx(w_s_idx), .o_rd0_valid(w_s_rvalid), .o_rd0_tag(w_s_rtag),
        .o_rd0_target(w_s_target), .o_rd0_cnt(w_s_cnt),
        .i_rd1_idx(w_j_idx), .o_rd1_valid(w_j_rvalid), .o_rd1_tag(w_j_rtag),
        .o_rd1_target(w_j_target), .o_rd1_cnt(w_j_cnt),
        .i_we(w_we), .i_wr_idx(w_j_idx), .i_wr_tag(w_j_tag),
        .i_wr_target(w_wr_target), .i_wr_cnt(w_wr_cnt)
    );

    always_comb begin
        w_s_pred    = w_s_rvalid && (w_s_rtag == w_s_tag) && w_s_cnt[CNT_W-1];
        w_j_hit     = w_j_rvalid && (w_j_rtag == w_j_tag);
        w_j_pred    = w_j_hit && w_j_cnt[CNT_W-1];
        w_mis       = (w_j_pred != iJUMP_HIT) || (w_j_pred && iJUMP_HIT && (w_j_target != iJUMP_ADDR));
        // a not-taken miss leaves the table alone; a flush drops the write
        w_we        = iJUMP_STB && !iFLUSH && (w_j_hit || iJUMP_HIT);
        w_wr_cnt    = !w_j_hit ? CNT_WEAK_TAKEN :
                      iJUMP_HIT ? CNT_W'(sat_inc(GEN_W'(w_j_cnt), CNT_W)) :
                      CNT_W'(sat_dec(GEN_W'(w_j_cnt)));
        w_wr_target = iJUMP_HIT ? iJUMP_ADDR : w_j_target;
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_valid <= 1'b0;
            r_pred  <= 1'b0;
            r_addr  <= '0;
        end else if (iFLUSH) begin
            r_valid <= 1'b0;
            r_pred  <= 1'b0;
        end else if (!iSEARCH_LOCK) begin
            r_valid <= iSEARCH_STB;
            r_pred  <= w_s_pred && iSEARCH_STB;
            r_addr  <= w_s_target;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) r_stat <= '0;
        else if (iJUMP_STB && w_mis && (r_stat != '1)) r_stat <= r_stat + STAT_W'(1);
    end

    assign oSEARCH_VALID          = r_valid;
    assign oSEARCH_PREDICT_BRANCH = r_pred;
    assign oSEARCH_ADDR           = r_addr;
    assign oSTAT_MISPREDICT       = r_stat;

endmodule

// File: tb/tb_branch_predictor_bimodal.sv
// tb_branch_predictor_bimodal: table-driven directed test of the bimodal BTB.
module tb_branch_predictor_bimodal;

    logic        clk = 1'b0;
    logic        rst, flush, s_stb, lock, j_stb, j_hit;
    logic [31:0] s_addr, j_addr, j_inst;
    logic        o_valid, o_pred;
    logic [31:0] o_addr, o_stat;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    branch_predictor_bimodal #(.ENTRY_N(16), .ADDR_W(32), .CNT_W(2), .STAT_W(32)) dut (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iFLUSH(flush),
        .iSEARCH_STB(s_stb), .iSEARCH_INST_ADDR(s_addr), .iSEARCH_LOCK(lock),
        .oSEARCH_VALID(o_valid), .oSEARCH_PREDICT_BRANCH(o_pred), .oSEARCH_ADDR(o_addr),
        .iJUMP_STB(j_stb), .iJUMP_HIT(j_hit), .iJUMP_ADDR(j_addr), .iJUMP_INST_ADDR(j_inst),
        .oSTAT_MISPREDICT(o_stat)
    );

    typedef struct {
        logic        s_stb;
        logic [31:0] s_addr;
        logic        lock, flush, j_stb, j_hit;
        logic [31:0] j_addr, j_inst;
        logic        e_valid, e_pred, c_addr;
        logic [31:0] e_addr, e_stat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ss, logic [31:0] sa, logic lk, logic fl, logic js, logic jh,
                                logic [31:0] ja, logic [31:0] ji, logic ev, logic ep, logic ca,
                                logic [31:0] ea, logic [31:0] st);
        vec_t v;
        v.s_stb = ss; v.s_addr = sa; v.lock = lk; v.flush = fl; v.j_stb = js; v.j_hit = jh;
        v.j_addr = ja; v.j_inst = ji; v.e_valid = ev; v.e_pred = ep; v.c_addr = ca;
        v.e_addr = ea; v.e_stat = st;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic idle();
        flush = 0; s_stb = 0; s_addr = 0; lock = 0; j_stb = 0; j_hit = 0; j_addr = 0; j_inst = 0;
    endtask

    initial begin
        //          stb addr          lk fl js jh jaddr         jinst         ev ep ca eaddr         stat
        vecs.push_back(mk(1, 32'h1000, 0, 0, 0, 0, 0,            0,            1, 0, 0, 0,            0));
        vecs.push_back(mk(0, 32'h0,    0, 0, 1, 1, 32'h2000,     32'h1000,     0, 0, 0, 0,            1));
        vecs.push_back(mk(1, 32'h1000, 0, 0, 0, 0, 0,            0,            1, 1, 1, 32'h2000,     1));
        vecs.push_back(mk(0, 32'h0,    0, 0, 1, 1, 32'h2000,     32'h1000,     0, 0, 0, 0,            1));
        vecs.push_back(mk(0, 32'h0,    0, 0, 1, 1, 32'h2000,     32'h1000,     0, 0, 0, 0,            1));
        vecs.push_back(mk(0, 32'h0,    0, 0, 1, 1, 32'h2000,     32'h1000,     0, 0, 0, 0,            1));
        vecs.push_back(mk(0, 32'h0,    0, 0, 1, 0, 0,            32'h1000,     0, 0, 0, 0,            2));
        vecs.push_back(mk(0, 32'h0,    0, 0, 1, 0, 0,            32'h1000,     0, 0, 0, 0,            3));
        vecs.push_back(mk(1, 32'h1000, 0, 0, 0, 0, 0,            0,            1, 0, 1, 32'h2000,     3));
        vecs.push_back(mk(0, 32'h0,    0, 0, 1, 0, 0,            32'h1000,     0, 0, 0, 0,            3));
        vecs.push_back(mk(0, 32'h0,    0, 0, 1, 0, 0,            32'h1000,     0, 0, 0, 0,            3));
        vecs.push_back(mk(0, 32'h0,    0, 0, 1, 1, 32'h2000,     32'h1000,     0, 0, 0, 0,            4));
        vecs.push_back(mk(1, 32'h1000, 0, 0, 0, 0, 0,            0,            1, 0, 1, 32'h2000,     4));
        vecs.push_back(mk(1, 32'h1040, 0, 0, 0, 0, 0,            0,            1, 0, 0, 0,            4));
        vecs.push_back(mk(0, 32'h0,    0, 0, 1, 1, 32'h5000,     32'h1040,     0, 0, 0, 0,            5));
        vecs.push_back(mk(1, 32'h1000, 0, 0, 0, 0, 0,            0,            1, 0, 1, 32'h5000,     5));
        vecs.push_back(mk(1, 32'h1040, 0, 0, 0, 0, 0,            0,            1, 1, 1, 32'h5000,     5));
        vecs.push_back(mk(0, 32'h0,    0, 0, 1, 1, 32'h6000,     32'h1040,     0, 0, 0, 0,            6));
        vecs.push_back(mk(1, 32'h1040, 0, 0, 0, 0, 0,            0,            1, 1, 1, 32'h6000,     6));
        vecs.push_back(mk(1, 32'h3000, 0, 0, 1, 1, 32'h3100,     32'h3000,     1, 0, 1, 32'h6000,     7));
        vecs.push_back(mk(1, 32'h3000, 0, 0, 0, 0, 0,            0,            1, 1, 1, 32'h3100,     7));
        vecs.push_back(mk(0, 32'h1000, 1, 0, 0, 0, 0,            0,            1, 1, 1, 32'h3100,     7));
        vecs.push_back(mk(0, 32'h1000, 1, 0, 0, 0, 0,            0,            1, 1, 1, 32'h3100,     7));
        vecs.push_back(mk(0, 32'h1000, 1, 0, 0, 0, 0,            0,            1, 1, 1, 32'h3100,     7));
        vecs.push_back(mk(0, 32'h1000, 0, 0, 0, 0, 0,            0,            0, 0, 1, 32'h3100,     7));
        vecs.push_back(mk(1, 32'h3000, 0, 0, 0, 0, 0,            0,            1, 1, 1, 32'h3100,     7));
        vecs.push_back(mk(1, 32'h3000, 1, 1, 1, 1, 32'h3200,     32'h3000,     0, 0, 0, 0,            8));
        vecs.push_back(mk(1, 32'h3000, 0, 0, 0, 0, 0,            0,            1, 0, 1, 32'h3100,     8));
        vecs.push_back(mk(1, 32'h1000, 0, 0, 0, 0, 0,            0,            1, 0, 0, 0,            8));
        vecs.push_back(mk(0, 32'h0,    0, 0, 1, 0, 0,            32'h3000,     0, 0, 0, 0,            8));

        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(o_valid), 0);
        chk("reset_pred", 32'(o_pred), 0);
        chk("reset_addr", o_addr, 0);
        chk("reset_stat", o_stat, 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            s_stb = vecs[i].s_stb; s_addr = vecs[i].s_addr; lock = vecs[i].lock;
            flush = vecs[i].flush; j_stb = vecs[i].j_stb; j_hit = vecs[i].j_hit;
            j_addr = vecs[i].j_addr; j_inst = vecs[i].j_inst;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
            chk($sformatf("row%0d_pred", i), 32'(o_pred), 32'(vecs[i].e_pred));
            chk($sformatf("row%0d_stat", i), o_stat, vecs[i].e_stat);
            if (vecs[i].c_addr) chk($sformatf("row%0d_addr", i), o_addr, vecs[i].e_addr);
            @(negedge clk);
        end

        idle();
        s_stb = 1; s_addr = 32'h1000;
        @(posedge clk);
        #1;
        chk("pre_reset_stat", o_stat, 8);
        @(negedge clk);
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        chk("rst2_stat", o_stat, 0);
        chk("rst2_valid", 32'(o_valid), 0);
        chk("rst2_addr", o_addr, 0);
        @(negedge clk);
        rst = 0;
        j_stb = 1; j_hit = 1; j_addr = 32'h7000; j_inst = 32'h1000;
        @(posedge clk);
        #1;
        chk("post_rst_alloc_stat", o_stat, 1);
        @(negedge clk);
        idle();
        s_stb = 1; s_addr = 32'h1000;
        @(posedge clk);
        #1;
        chk("post_rst_hit_pred", 32'(o_pred), 1);
        chk("post_rst_hit_addr", o_addr, 32'h7000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
